// File: rtl/mux_matrix_pkg.sv
// Shared types and default constants for the mux matrix readout sequencer.
package mux_matrix_pkg;

    localparam int SETTLE_1MS = 100000;
    localparam int ADC_WIDTH  = 12;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONVERT,
        ST_WAIT_ADC,
        ST_OUTPUT,
        ST_ADVANCE
    } scan_state_e;

endpackage

// File: rtl/mux_matrix_scanner_settle_timer.sv
// Settle delay counter: cleared on every address change, done_o marks the
// final settle cycle so the next clock can request a conversion.
module settle_timer
    import mux_matrix_pkg::*;
#(
    parameter int SettleCycles = SETTLE_1MS,
    parameter int CntWidth     = 17
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam logic [CntWidth-1:0] LAST = CntWidth'(SettleCycles - 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/mux_matrix_scanner.sv
// Timed row/column scan of the bolometer mux: settle, convert, emit one
// tagged sample per cell on a valid/ready stream, column index fastest.
module mux_matrix_scanner
    import mux_matrix_pkg::*;
#(
    parameter int Width        = ADDR_WIDTH,
    parameter int Rows         = 2,
    parameter int Cols         = 2,
    parameter int DataWidth    = ADC_WIDTH,
    parameter int SettleCycles = SETTLE_1MS,
    parameter int CntWidth     = 17
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 continuous_i,
    output logic                 adc_start_o,
    input  logic                 adc_done_i,
    input  logic [DataWidth-1:0] adc_data_i,
    output logic [Width-1:0]     row_o,
    output logic [Width-1:0]     col_o,
    output logic                 mux_en_o,
    output logic                 dev_pol_a_o,
    output logic                 dev_pol_b_o,
    output logic                 pix_valid_o,
    input  logic                 pix_ready_i,
    output logic [DataWidth-1:0] pix_data_o,
    output logic [Width-1:0]     pix_row_o,
    output logic [Width-1:0]     pix_col_o,
    output logic                 frame_done_o,
    output logic                 busy_o
);

    localparam logic [Width-1:0] LAST_ROW = Width'(Rows - 1);
    localparam logic [Width-1:0] LAST_COL = Width'(Cols - 1);

    scan_state_e          state_q, state_d;
    logic [Width-1:0]     row_q, row_d, col_q, col_d;
    logic [DataWidth-1:0] pix_data_q, pix_data_d;
    logic [Width-1:0]     pix_row_q, pix_row_d, pix_col_q, pix_col_d;
    logic                 tmr_clr, tmr_done;

    settle_timer #(
        .SettleCycles (SettleCycles),
        .CntWidth     (CntWidth)
    ) u_settle (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (tmr_clr),
        .en_i   (state_q == ST_SETTLE),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        pix_data_d   = pix_data_q;
        pix_row_d    = pix_row_q;
        pix_col_d    = pix_col_q;
        tmr_clr      = 1'b0;
        frame_done_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    row_d   = '0;
                    col_d   = '0;
                    tmr_clr = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_done)
                    state_d = ST_CONVERT;
            end
            ST_CONVERT: state_d = ST_WAIT_ADC;
            ST_WAIT_ADC: begin
                if (adc_done_i) begin
                    pix_data_d = adc_data_i;
                    pix_row_d  = row_q;
                    pix_col_d  = col_q;
                    state_d    = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                // Address and capture registers hold until the sample is taken.
                if (pix_ready_i)
                    state_d = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                tmr_clr = 1'b1;
                state_d = ST_SETTLE;
                if (col_q != LAST_COL) begin
                    col_d = col_q + 1'b1;
                end else if (row_q != LAST_ROW) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    frame_done_o = 1'b1;
                    row_d        = '0;
                    col_d        = '0;
                    if (!continuous_i)
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            pix_data_q <= '0;
            pix_row_q  <= '0;
            pix_col_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            pix_data_q <= pix_data_d;
            pix_row_q  <= pix_row_d;
            pix_col_q  <= pix_col_d;
        end
    end

    assign row_o       = row_q;
    assign col_o       = col_q;
    assign mux_en_o    = (state_q == ST_IDLE);
    assign adc_start_o = (state_q == ST_CONVERT);
    assign pix_valid_o = (state_q == ST_OUTPUT);
    assign busy_o      = (state_q != ST_IDLE);
    assign pix_data_o  = pix_data_q;
    assign pix_row_o   = pix_row_q;
    assign pix_col_o   = pix_col_q;
    assign dev_pol_a_o = 1'b1;
    assign dev_pol_b_o = 1'b0;

endmodule

// File: tb/tb_mux_matrix_scanner.sv
// Directed bench for mux_matrix_scanner: 2x2 scan, 4-cycle settle, ADC model
// answering 3 clocks after each request with row*16+col+0x100.
module tb_mux_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        continuous_i = 1'b0;
    logic        adc_start_o;
    logic        adc_done_i = 1'b0;
    logic [11:0] adc_data_i = '0;
    logic [4:0]  row_o, col_o;
    logic        mux_en_o, dev_pol_a_o, dev_pol_b_o;
    logic        pix_valid_o;
    logic        pix_ready_i = 1'b1;
    logic [11:0] pix_data_o;
    logic [4:0]  pix_row_o, pix_col_o;
    logic        frame_done_o, busy_o;

    int n_chk = 0;
    int n_err = 0;

    mux_matrix_scanner #(
        .Width(5), .Rows(2), .Cols(2), .DataWidth(12), .SettleCycles(4), .CntWidth(3)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .continuous_i(continuous_i),
        .adc_start_o(adc_start_o), .adc_done_i(adc_done_i), .adc_data_i(adc_data_i),
        .row_o(row_o), .col_o(col_o), .mux_en_o(mux_en_o),
        .dev_pol_a_o(dev_pol_a_o), .dev_pol_b_o(dev_pol_b_o),
        .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i), .pix_data_o(pix_data_o),
        .pix_row_o(pix_row_o), .pix_col_o(pix_col_o),
        .frame_done_o(frame_done_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ADC model: one-cycle done three clocks after each request.
    int   cd = 0;
    logic spur_req = 1'b0;
    logic adc_spur = 1'b0;
    logic [4:0] m_row, m_col;
    always @(posedge clk) begin
        #1;
        adc_done_i = 1'b0;
        adc_spur   = 1'b0;
        if (spur_req) begin
            adc_done_i = 1'b1;
            adc_data_i = 12'hFFF;
            adc_spur   = 1'b1;
            spur_req   = 1'b0;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                adc_done_i = 1'b1;
                adc_data_i = 12'h100 + {3'b0, m_row, 4'b0} + {7'b0, m_col};
            end
        end
        if (adc_start_o === 1'b1) begin
            cd    = 3;
            m_row = row_o;
            m_col = col_o;
        end
    end

    // Monitor: settle timing, pixel latency, accepted pixels, frame pulses.
    logic [21:0] px_q[$];
    int   fd_cnt = 0, n_starts = 0, cyc = 0, chg_cyc = 0;
    logic [4:0] prow = '0, pcol = '0;
    logic pmux = 1'b1, lat_pend = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if ((row_o != prow) || (col_o != pcol) || (!mux_en_o && pmux))
            chg_cyc = cyc;
        prow = row_o;
        pcol = col_o;
        pmux = mux_en_o;
        if (adc_start_o === 1'b1) begin
            n_starts++;
            chk("settle_len", 32'(cyc - chg_cyc), 32'd4);
        end
        if (lat_pend)
            chk("pix_latency", 32'(pix_valid_o), 32'd1);
        lat_pend = (adc_done_i === 1'b1) && !adc_spur;
        if (pix_valid_o === 1'b1 && pix_ready_i)
            px_q.push_back({pix_row_o, pix_col_o, pix_data_o});
        if (frame_done_o === 1'b1)
            fd_cnt++;
    end

    logic [21:0] exp_px [4] = '{{5'd0, 5'd0, 12'h100}, {5'd0, 5'd1, 12'h101},
                                {5'd1, 5'd0, 12'h110}, {5'd1, 5'd1, 12'h111}};

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic wait_fd(input int n);
        int t = 0;
        while (fd_cnt < n && t < 400) begin
            @(posedge clk);
            t++;
        end
        chk("frame_wait", 32'(fd_cnt >= n), 32'd1);
    endtask

    task automatic wait_valid();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (pix_valid_o !== 1'b1 && t < 100);
        chk("valid_wait", 32'(pix_valid_o), 32'd1);
    endtask

    task automatic check_px(input int base, input int n);
        chk("px_count", 32'(px_q.size()), 32'(base + n));
        for (int i = 0; i < n && base + i < px_q.size(); i++)
            chk($sformatf("px%0d", i), 32'(px_q[base + i]), 32'(exp_px[i % 4]));
    endtask

    task automatic check_idle_after(input int fd_exp);
        @(negedge clk);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_mux_en", 32'(mux_en_o), 32'd1);
        repeat (20) @(negedge clk);
        chk("stay_idle", 32'(busy_o), 32'd0);
        chk("fd_count", 32'(fd_cnt), 32'(fd_exp));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int base_fd, base_px, st_snap, t;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_row", 32'(row_o), 32'd0);
        chk("rst_col", 32'(col_o), 32'd0);
        chk("rst_mux_en", 32'(mux_en_o), 32'd1);
        chk("rst_adc_start", 32'(adc_start_o), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid_o), 32'd0);
        chk("rst_pix_data", 32'(pix_data_o), 32'd0);
        chk("rst_pix_row", 32'(pix_row_o), 32'd0);
        chk("rst_pix_col", 32'(pix_col_o), 32'd0);
        chk("rst_frame_done", 32'(frame_done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("pol_a", 32'(dev_pol_a_o), 32'd1);
        chk("pol_b", 32'(dev_pol_b_o), 32'd0);
        rst_i = 1'b1;

        // Single frame
        base_fd = fd_cnt; base_px = px_q.size();
        pulse_start();
        wait_fd(base_fd + 1);
        check_px(base_px, 4);
        check_idle_after(base_fd + 1);

        // Backpressure on pixel (0,1)
        base_fd = fd_cnt; base_px = px_q.size();
        pulse_start();
        t = 0;
        while (px_q.size() < base_px + 1 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1 pix_ready_i = 1'b0;
        wait_valid();
        st_snap = n_starts;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(pix_valid_o), 32'd1);
            chk("bp_data", 32'(pix_data_o), 32'h101);
            chk("bp_tag", 32'({pix_row_o, pix_col_o}), 32'h001);
            chk("bp_addr", 32'({row_o, col_o}), 32'h001);
            chk("bp_mux_en", 32'(mux_en_o), 32'd0);
            @(negedge clk);
        end
        chk("bp_no_start", 32'(n_starts), 32'(st_snap));
        @(posedge clk); #1 pix_ready_i = 1'b1;
        wait_fd(base_fd + 1);
        check_px(base_px, 4);
        check_idle_after(base_fd + 1);

        // Continuous mode: three frames, drop continuous_i during the third
        base_fd = fd_cnt; base_px = px_q.size();
        @(posedge clk); #1 continuous_i = 1'b1;
        pulse_start();
        wait_fd(base_fd + 2);
        t = 0;
        while (px_q.size() < base_px + 9 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1 continuous_i = 1'b0;
        wait_fd(base_fd + 3);
        check_px(base_px, 12);
        check_idle_after(base_fd + 3);

        // start_i during WAIT_ADC and a spurious adc_done_i in SETTLE
        base_fd = fd_cnt; base_px = px_q.size();
        pulse_start();
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (adc_start_o !== 1'b1 && t < 100);
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        t = 0;
        while (px_q.size() < base_px + 1 && t < 100) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk) spur_req = 1'b1;
        wait_fd(base_fd + 1);
        check_px(base_px, 4);
        check_idle_after(base_fd + 1);

        // Reset while a pixel is stalled in OUTPUT
        base_fd = fd_cnt;
        @(posedge clk); #1 pix_ready_i = 1'b0;
        pulse_start();
        wait_valid();
        rst_i = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(pix_valid_o), 32'd0);
        chk("abort_addr", 32'({row_o, col_o}), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_mux_en", 32'(mux_en_o), 32'd1);
        rst_i = 1'b1;
        pix_ready_i = 1'b1;
        base_px = px_q.size();
        repeat (5) @(negedge clk);
        chk("abort_no_px", 32'(px_q.size()), 32'(base_px));
        chk("abort_no_fd", 32'(fd_cnt), 32'(base_fd));
        pulse_start();
        wait_fd(base_fd + 1);
        check_px(base_px, 4);
        check_idle_after(base_fd + 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mux_matrix_scanner.md
Name: mux_matrix_scanner

Overview:
- Automatic readout sequencer for the 2x2 microbolometer mux matrix; replaces button-stepped row/column selection with a timed scan.
- Drives the mux row/column address and enable, waits a settle time, then triggers an external ADC and collects the conversion.
- Emits one tagged pixel sample per matrix cell over a valid/ready stream toward the downstream logger/UART path.

Parameters:
- Width, 5, row/column address width (matches mux address pins).
- Rows, 2, number of rows scanned (addresses 0..Rows-1).
- Cols, 2, number of columns scanned (addresses 0..Cols-1).
- DataWidth, 12, ADC sample width.
- SettleCycles, 100000, clocks between address change and ADC start (1 ms at 100 MHz); must be >= 1.
- CntWidth, 17, settle counter width; must satisfy 2^CntWidth > SettleCycles.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset. Reset is synchronous and active-low.
- start_i  in  1  one-cycle pulse that starts a frame scan; ignored unless idle.
- continuous_i  in  1  level; sampled at end of frame; 1 = restart immediately.
- adc_start_o  out  1  one-cycle conversion request.
- adc_done_i  in  1  one-cycle pulse, conversion complete.
- adc_data_i  in  DataWidth  sample, valid when adc_done_i=1.
- row_o  out  Width  mux row address.
- col_o  out  Width  mux column address.
- mux_en_o  out  1  mux enable, active-low (0 = enabled).
- dev_pol_a_o  out  1  device polarity A, constant 1.
- dev_pol_b_o  out  1  device polarity B, constant 0.
- pix_valid_o  out  1  pixel sample valid.
- pix_ready_i  in  1  downstream ready.
- pix_data_o  out  DataWidth  captured sample.
- pix_row_o  out  Width  row tag of sample.
- pix_col_o  out  Width  column tag of sample.
- frame_done_o  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- busy_o  out  1  1 in any state except IDLE.

Behaviour:
- Reset (rst_i=0 at clock edge): state IDLE; row_o=col_o=0; mux_en_o=1; adc_start_o=0; pix_valid_o=0; pix_data_o/pix_row_o/pix_col_o=0; frame_done_o=0; busy_o=0.
- Reset mid-scan aborts immediately: no partial pixel is emitted, and any late adc_done_i is ignored.
- FSM states: IDLE, SETTLE, CONVERT, WAIT_ADC, OUTPUT, ADVANCE.
- IDLE: mux_en_o=1. On start_i=1: row=col=0, mux_en_o=0, counter cleared, go to SETTLE.
- SETTLE: counter increments each clock. When counter==SettleCycles-1, go to CONVERT.
  - Minimum settle from an address change to adc_start_o is SettleCycles clocks.
- CONVERT: adc_start_o=1 for exactly one cycle, then WAIT_ADC.
- WAIT_ADC: hold until adc_done_i=1. Then capture adc_data_i, row, and col into pix_* and go to OUTPUT.
  - adc_done_i in any other state is ignored.
- OUTPUT: pix_valid_o=1. pix_* are stable while pix_valid_o=1 and pix_ready_i=0.
  - Transfer occurs on the cycle where valid and ready are both 1.
  - Then pix_valid_o=0 next cycle and go to ADVANCE.
  - Address is held (mux enabled) during backpressure.
- ADVANCE (one cycle), column fastest:
  - If col<Cols-1: col+1.
  - Else if row<Rows-1: col=0, row+1.
  - Else frame end: frame_done_o=1 this cycle, row=col=0.
    - If continuous_i=1: SETTLE.
    - Else: IDLE, with mux_en_o=1 from the following cycle.
  - Non-end transitions always go to SETTLE with the counter cleared.
- Scan order for 2x2: (0,0),(0,1),(1,0),(1,1).
- start_i while busy_o=1 is ignored (no queuing).
- continuous_i is sampled only in ADVANCE at frame end; deasserting it mid-frame completes the current frame.
- Addresses are zero-extended to Width; Rows and Cols must each be <= 2^Width.
- Pixel latency: adc_done_i cycle to pix_valid_o=1 is 1 clock.

Decomposition:
- Shared package mux_matrix_pkg:
  - FSM state enum.
  - Default constants: SETTLE_1MS=100000, ADC_WIDTH=12, ADDR_WIDTH=5.
- One natural sub-module: settle_timer. Load/clear input, done output at SettleCycles-1; parameterised on CntWidth.
- Address advance and FSM stay in the top.

Test Plan:
- Reset values: hold rst_i=0 for 3 clocks -> all outputs at reset values, mux_en_o=1, busy_o=0.
- Single frame (SettleCycles=4, ADC model done after 3 clocks with data=row*16+col+0x100, pix_ready_i=1), start_i pulse:
  - 4 pixels in order (0,0)=0x100, (0,1)=0x101, (1,0)=0x110, (1,1)=0x111.
  - adc_start_o exactly 4 clocks after each address change.
  - frame_done_o one pulse, then IDLE with mux_en_o=1.
- Backpressure: pix_ready_i=0 for 10 clocks on pixel (0,1) -> pix_valid_o held, data 0x101 stable, row_o/col_o unchanged, no new adc_start_o.
- Continuous mode: continuous_i=1, start_i once -> 3 back-to-back frames (12 pixels).
  - Drop continuous_i mid-frame 3 -> frame 3 completes, then IDLE.
- Ignored events: start_i during WAIT_ADC -> no effect. Spurious adc_done_i in SETTLE -> no pixel emitted, settle count unaffected.
- Reset mid-operation: rst_i=0 during OUTPUT with pix_ready_i=0 -> next cycle pix_valid_o=0, row_o=col_o=0, busy_o=0.
  - A following start_i begins a fresh frame at (0,0).
